mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port block RAM between the multi-cycle CPU and one I/O requester
//  (display fetch / DMA). Muxes address, write data and write enable each cycle.
//  Returns read data with the tag of the owning port. Stalls the CPU controller when it loses.
//  Sits between the CPU memory bus and the RAM; the controller FSM holds its state while cpu_stall=1.
// PARAMETERS
//  WIDTH     16  data and address width
//  MAX_WAIT  4   consecutive denied io cycles before io is forced ahead of CPU (>=1)
//  RD_LAT    1   RAM read latency in cycles (>=1)
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  reset      in   1      synchronous, active-high
//  cpu_req    in   1      CPU memory access this cycle (read or write)
//  cpu_we     in   1      1=write, 0=read
//  cpu_addr   in   WIDTH  CPU address
//  cpu_wdata  in   WIDTH  CPU write data
//  cpu_stall  out  1      CPU request not served this cycle; hold request
//  cpu_rdata  out  WIDTH  read data to CPU (registered)
//  cpu_rvalid out  1      cpu_rdata valid, single-cycle pulse
//  io_req     in   1      io access request; held until io_gnt
//  io_we      in   1      1=write, 0=read
//  io_addr    in   WIDTH  io address
//  io_wdata   in   WIDTH  io write data
//  io_gnt     out  1      io request served this cycle (combinational)
//  io_rdata   out  WIDTH  read data to io (registered)
//  io_rvalid  out  1      io_rdata valid, single-cycle pulse
//  mem_addr   out  WIDTH  RAM address
//  mem_we     out  1      RAM write enable
//  mem_wdata  out  WIDTH  RAM write data
//  mem_rdata  in   WIDTH  RAM read data, valid RD_LAT cycles after address
// BEHAVIOUR
//  - Grant is combinational, one port per cycle:
//    io wins if io_req && (!cpu_req || starve_cnt==MAX_WAIT); otherwise CPU wins if cpu_req.
//  - cpu_stall = cpu_req && !cpu_gnt. io_gnt = io wins. Neither requesting -> mem_we=0, mem_addr=0.
//  - starve_cnt register: cleared on reset, on io_gnt, or when io_req=0.
//    Incremented when io_req && !io_gnt. Saturates at MAX_WAIT.
//  - Both requesting continuously -> CPU,CPU,CPU,CPU,IO repeating (MAX_WAIT=4).
//  - mem_addr, mem_wdata and mem_we follow the granted port.
//    mem_we = granted port's we, forced 0 while reset=1.
//  - Read tag pipeline: depth RD_LAT, entries {valid, port}.
//    A granted read enters {1,port}. A write or an idle cycle enters {0,x}.
//  - Tag exiting the pipe with valid=1 drives the matching rvalid next cycle.
//    mem_rdata is captured into that port's rdata register in the same cycle.
//    Total read latency = RD_LAT+1 cycles from grant. Writes produce no rvalid.
//  - Each rdata register holds its last value between reads.
//  - Back-to-back reads from alternating ports are supported.
//    Tags keep ordering; no lost or duplicated rvalid.
//  - Reset (any cycle, incl. mid-read): starve_cnt=0, all tags invalid, rvalid=0, rdata=0.
//    In-flight reads are dropped; no rvalid may appear after reset deasserts for a pre-reset read.
//  - Same-cycle write+read to one address by different ports: the granted one executes;
//    the loser retries next cycle and sees the RAM's post-write contents.
// STRUCTURE
//  - Shared package: PORT_CPU=1'b0, PORT_IO=1'b1, tag struct {valid, port}.
//  - One sub-module: rd_tag_pipe (parameterised RD_LAT shift register with sync reset).
//  - Grant logic and starve counter stay in the top module.
// TESTING
//  - CPU only, read 0x0010 (RAM=0xBEEF): cpu_stall=0; cpu_rvalid pulses 2 cycles later, cpu_rdata=0xBEEF.
//  - Both req held 10 cycles: grants CPU x4, IO x1, CPU x4, IO x1; cpu_stall high exactly on the IO cycles.
//  - io write 0x0020<=0x1234 while CPU idle: io_gnt=1 same cycle, mem_we=1; no rvalid on either port.
//  - Alternate cpu read 0x1 / io read 0x2 (RAM 0xAAAA/0x5555): cpu_rdata=0xAAAA, io_rdata=0x5555.
//    Each rvalid pulses once, in issue order.
//  - Reset asserted 1 cycle after CPU read grant: no cpu_rvalid afterwards, outputs 0, starve_cnt=0.
//  - RD_LAT=2 build, CPU read: cpu_rvalid 3 cycles after grant, correct data.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: port identifiers and read tag type shared by the arbiter and its tag pipe
package mem_port_arbiter_pkg;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_IO = 1'b1;
  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;
endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// rd_tag_pipe: RD_LAT-deep shift register carrying read tags alongside the RAM read latency
module rd_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t d,
  output tag_t q
);
  tag_t pipe [RD_LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign q = pipe[RD_LAT-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between the CPU and an io requester with starvation limit
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int MAX_WAIT = 4,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_stall,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             cpu_rvalid,
  input  logic             io_req,
  input  logic             io_we,
  input  logic [WIDTH-1:0] io_addr,
  input  logic [WIDTH-1:0] io_wdata,
  output logic             io_gnt,
  output logic [WIDTH-1:0] io_rdata,
  output logic             io_rvalid,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] SAT = CW'(MAX_WAIT);
  logic          cpu_gnt;
  logic [CW-1:0] starve_cnt;
  tag_t          tag_in;
  tag_t          tag_out;
  always_comb begin
    io_gnt = io_req && (!cpu_req || starve_cnt == SAT);
    cpu_gnt = cpu_req && !io_gnt;
    cpu_stall = cpu_req && !cpu_gnt;
    mem_addr = io_gnt ? io_addr : cpu_gnt ? cpu_addr : '0;
    mem_wdata = io_gnt ? io_wdata : cpu_gnt ? cpu_wdata : '0;
    mem_we = !reset && (io_gnt ? io_we : cpu_gnt && cpu_we);
    tag_in.valid = (io_gnt && !io_we) || (cpu_gnt && !cpu_we);
    tag_in.port = io_gnt ? PORT_IO : PORT_CPU;
  end
  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_tags (
    .clk(clk),
    .rst(reset),
    .d  (tag_in),
    .q  (tag_out)
  );
  // data is captured in the same cycle the tag leaves the pipe, so rvalid and rdata line up
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
      cpu_rvalid <= 1'b0;
      io_rvalid <= 1'b0;
      cpu_rdata <= '0;
      io_rdata <= '0;
    end else begin
      starve_cnt <= (io_gnt || !io_req) ? '0 : starve_cnt + CW'(starve_cnt != SAT);
      cpu_rvalid <= tag_out.valid && tag_out.port == PORT_CPU;
      io_rvalid <= tag_out.valid && tag_out.port == PORT_IO;
      if (tag_out.valid && tag_out.port == PORT_CPU) cpu_rdata <= mem_rdata;
      if (tag_out.valid && tag_out.port == PORT_IO) io_rdata <= mem_rdata;
    end
  end
endmodule
